// File: rtl/risc_run_pkg.sv
// Shared state encoding, stop-cause codes and stop-priority helper for the
// run controller.
package risc_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_STOP = 2'b11
  } run_state_t;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALT    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_ABORT   = 2'b11;

  // Breakpoint shares the abort code; abort and breakpoint outrank halt and timeout.
  function automatic logic [1:0] stop_cause(input logic abort_hit, input logic bp_hit,
                                            input logic halt_hit, input logic timeout_hit);
    logic [1:0] cause;
    if (abort_hit || bp_hit) begin
      cause = STAT_ABORT;
    end else if (halt_hit) begin
      cause = STAT_HALT;
    end else if (timeout_hit) begin
      cause = STAT_TIMEOUT;
    end else begin
      cause = STAT_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/risc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc
// and the count sticks at all-ones instead of wrapping.
module risc_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = W'(1);

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/risc_run_ctrl.sv
// Run/step controller gating a core clock enable; stops on abort, halt,
// cycle budget or (with RISC_RUN_CTRL_BREAKPOINT_EN defined) a PC breakpoint.
module risc_run_ctrl
  import risc_run_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PC_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             halt_in,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt
);

  run_state_t     state;
  run_state_t     state_nxt;
  logic           running;
  logic           accept_start;
  logic           abort_hit;
  logic           bp_hit;
  logic           halt_hit;
  logic           timeout_hit;
  logic           stop_hit;
  logic [1:0]     cause;
  logic [CNT_W:0] cnt_plus_one;

  assign running      = (state == ST_RUN) || (state == ST_STEP);
  assign abort_hit    = running && abort;
  assign halt_hit     = running && halt_in;
  // One extra bit keeps the saturated count from aliasing onto a small limit.
  assign cnt_plus_one = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit  = running && (cycle_limit != {CNT_W{1'b0}}) &&
                        (cnt_plus_one == {1'b0, cycle_limit});

`ifdef RISC_RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = running && (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{1'b0, pc, bp_addr};
`endif

  assign cause    = stop_cause(abort_hit, bp_hit, halt_hit, timeout_hit);
  assign stop_hit = (cause != STAT_NONE);

  // Next-state selection; start beats step, both ignored while running.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      ST_IDLE, ST_STOP: begin
        if (start) begin
          state_nxt    = ST_RUN;
          accept_start = 1'b1;
        end else if (step) begin
          state_nxt = ST_STEP;
        end else begin
          state_nxt = state;
        end
      end
      ST_RUN: begin
        if (stop_hit) begin
          state_nxt = ST_STOP;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        if (stop_hit) begin
          state_nxt = ST_STOP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      core_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      status  <= STAT_NONE;
    end else begin
      state   <= state_nxt;
      core_en <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      busy    <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      done    <= (state_nxt == ST_STOP) && (state != ST_STOP);
      if (accept_start) begin
        status <= STAT_NONE;
      end else if (running && stop_hit) begin
        status <= cause;
      end else begin
        status <= status;
      end
    end
  end

  risc_sat_counter #(
    .W(CNT_W)
  ) u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_start),
    .inc   (core_en),
    .count (cycle_cnt)
  );

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Randomized scoreboard bench for risc_run_ctrl (CNT_W=4 so saturation is reachable).
module tb_risc_run_ctrl;

  localparam int CW   = 4;
  localparam int PW   = 16;
  localparam int CMAX = 15;
`ifdef RISC_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start, step, abort, halt_in;
  logic [CW-1:0] cycle_limit;
  logic [PW-1:0] pc, bp_addr;
  logic          core_en, busy, done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_cnt;

  typedef struct {
    logic [1:0] st;
    int         cnt;
    int         en;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         en_total = 0;
  int         m_cnt = 0;
  int         m_en = 0;
  logic [1:0] m_status = 2'b00;

  risc_run_ctrl #(.CNT_W(CW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .abort(abort),
    .cycle_limit(cycle_limit), .halt_in(halt_in), .pc(pc), .bp_addr(bp_addr),
    .core_en(core_en), .busy(busy), .done(done), .status(status), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] cause_of(input bit a, input bit bp, input bit h, input bit t);
    if (a || bp) return 2'b11;
    if (h) return 2'b01;
    if (t) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [PW-1:0] pc_other();
    logic [PW-1:0] v;
    v = PW'($urandom);
    if (v == bp_addr) v = v ^ 16'h0001;
    return v;
  endfunction

  // Monitor: counts enabled cycles and checks every done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_en) en_total++;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1 expected no stop (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("stop_status", int'(status), int'(e.st));
            chk("stop_cnt", int'(cycle_cnt), e.cnt);
            chk("en_cycles", en_total, e.en);
          end
        end
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      halt_in = 1'($urandom_range(0, 1));
      abort   = 1'($urandom_range(0, 1));
      pc      = PW'($urandom);
    end
    @(negedge clk);
    halt_in = 1'b0;
    abort   = 1'b0;
  endtask

  // Free run: h/a/b give the enabled cycle (1-based) of halt, abort, breakpoint; 0 = never.
  task automatic run_txn(input int lim, input int h, input int a, input int b);
    int n;
    logic [1:0] st;
    exp_t e;
    m_cnt = 0;
    n = 0;
    st = 2'b00;
    while (st == 2'b00 && n < 100) begin
      n++;
      st = cause_of(n == a, BP_ON && n == b, n == h, lim != 0 && m_cnt + 1 == lim);
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_en++;
    end
    m_status = st;
    e.st = st; e.cnt = m_cnt; e.en = m_en;
    sb.push_back(e);
    @(negedge clk);
    cycle_limit = lim[CW-1:0];
    start = 1'b1;
    step = 1'($urandom_range(0, 1));
    halt_in = 1'b0;
    abort = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start   = 1'($urandom_range(0, 1));
      step    = 1'($urandom_range(0, 1));
      halt_in = (i == h);
      abort   = (i == a);
      pc      = (i == b) ? bp_addr : pc_other();
    end
    @(negedge clk);
    start = 1'b0; step = 1'b0; halt_in = 1'b0; abort = 1'b0;
    drain();
  endtask

  task automatic step_txn(input int lim, input bit h, input bit a, input bit b);
    logic [1:0] st;
    exp_t e;
    st = cause_of(a, BP_ON && b, h, lim != 0 && m_cnt + 1 == lim);
    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    m_en++;
    if (st != 2'b00) begin
      m_status = st;
      e.st = st; e.cnt = m_cnt; e.en = m_en;
      sb.push_back(e);
    end
    @(negedge clk);
    cycle_limit = lim[CW-1:0];
    step = 1'b1; start = 1'b0; halt_in = 1'b0; abort = 1'b0;
    @(negedge clk);
    step    = 1'($urandom_range(0, 1));
    start   = 1'($urandom_range(0, 1));
    halt_in = h;
    abort   = a;
    pc      = b ? bp_addr : pc_other();
    @(negedge clk);
    step = 1'b0; start = 1'b0; halt_in = 1'b0; abort = 1'b0;
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_core_en"}, int'(core_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_status"}, int'(status), 0);
    chk({tag, "_cnt"}, int'(cycle_cnt), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pulse");
    m_cnt = 0;
    m_status = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset lands between edges while running with cycle_cnt=4; released so the next edge takes a start.
  task automatic reset_mid_run();
    m_cnt = 0;
    m_status = 2'b00;
    @(negedge clk);
    cycle_limit = '0; start = 1'b1; step = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0; halt_in = 1'b0; abort = 1'b0; pc = pc_other();
    end
    @(posedge clk);
    #1;
    m_en += 4;
    chk("pre_reset_cnt", int'(cycle_cnt), 4);
    chk("pre_reset_core_en", int'(core_en), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_rst");
    m_cnt = 0;
    m_status = 2'b00;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lim, h, a, b;
    start = 1'b0; step = 1'b0; abort = 1'b0; halt_in = 1'b0;
    cycle_limit = '0; pc = '0; bp_addr = 16'h0003;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(10, 0, 0, 0);
    idle(3);
    run_txn(0, 7, 0, 0);
    idle(2);

    pulse_reset();
    repeat (3) begin
      step_txn(0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("steps_cnt", int'(cycle_cnt), m_cnt);
    chk("steps_status", int'(status), int'(m_status));
    chk("steps_core_en", int'(core_en), 0);
    chk("steps_busy", int'(busy), 0);

    step_txn(4, 1'b0, 1'b0, 1'b0);
    step_txn(0, 1'b1, 1'b0, 1'b0);
    step_txn(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("step_status_hold", int'(status), int'(m_status));
    chk("step_cnt_hold", int'(cycle_cnt), m_cnt);

    run_txn(5, 5, 5, 0);
    reset_mid_run();
    run_txn(6, 0, 0, 0);
    run_txn(0, 0, 20, 0);
    bp_addr = 16'h0003;
    run_txn(0, 3, 9, 3);
    idle(2);

    for (int t = 0; t < 30; t++) begin
      bp_addr = PW'($urandom);
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 6) begin
        h = int'($urandom_range(0, 18));
        a = int'($urandom_range(1, 25));
        b = int'($urandom_range(0, 18));
        run_txn(lim, h, a, b);
      end else begin
        step_txn(lim, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
      end
      idle(int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("final_en_total", en_total, m_en);
    chk("final_cnt", int'(cycle_cnt), m_cnt);
    chk("final_status", int'(status), int'(m_status));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_run_ctrl.md
RISC_RUN_CTRL -- requirements
Module: risc_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of cycle counter and cycle limit.
REQ-002 SHALL have parameter PC_W, default 16, width of core program counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a free run.
REQ-006 SHALL have port step  input  1  single-cycle request to execute exactly one core cycle.
REQ-007 SHALL have port abort  input  1  level; forces stop.
REQ-008 SHALL have port cycle_limit  input  CNT_W  run budget in core cycles; 0 = unlimited.
REQ-009 SHALL have port halt_in  input  1  core HALT-decode flag, sampled only when core_en=1.
REQ-010 SHALL have port pc  input  PC_W  current core program counter.
REQ-011 SHALL have port bp_addr  input  PC_W  breakpoint address (used only under REQ-030).
REQ-012 SHALL have port core_en  output  1  core clock enable.
REQ-013 SHALL have port busy  output  1  high in RUN and STEP.
REQ-014 SHALL have port done  output  1  one-cycle pulse on entry to STOP.
REQ-015 SHALL have port status  output  2  stop cause: 00 none, 01 halt, 10 timeout, 11 abort/breakpoint.
REQ-016 SHALL have port cycle_cnt  output  CNT_W  core cycles executed since last start.

Function
REQ-017 SHALL implement states IDLE, RUN, STEP, STOP; core_en=1 in RUN, and in STEP for exactly one cycle; core_en=0 in IDLE, STOP.
REQ-018 IDLE/STOP + start -> RUN next cycle; cycle_cnt cleared to 0 and status to 00 on the same edge.
REQ-019 IDLE/STOP + step (start low) -> STEP for one cycle, then IDLE; cycle_cnt and status not cleared.
REQ-020 start and step same cycle: start wins; start or step in RUN/STEP: ignored.
REQ-021 cycle_cnt SHALL increment by 1 on every edge where core_en=1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 Timeout: enabled cycle where cycle_limit!=0 and cycle_cnt+1==cycle_limit -> STOP, status 10; exactly cycle_limit enabled cycles executed.
REQ-023 halt_in=1 during an enabled cycle -> STOP, status 01; that cycle still counted.
REQ-024 abort=1 in RUN/STEP -> STOP, status 11, core_en low from the following cycle; abort in IDLE/STOP: no effect.
REQ-025 Simultaneous stop causes priority: abort > breakpoint > halt > timeout.
REQ-026 STEP with stop cause -> STOP (with done) instead of IDLE.
REQ-027 done SHALL pulse exactly once per STOP entry; status holds until next start.
REQ-028 Outputs registered; stop takes effect with one-cycle latency (the triggering cycle is the last enabled cycle).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, core_en=0, busy=0, done=0, status=00, cycle_cnt=0, including mid-RUN; release synchronous to clk, first start accepted on first edge after release.

Configuration
REQ-030 Macro RISC_RUN_CTRL_BREAKPOINT_EN: defined -> enabled cycle with pc==bp_addr stops to STOP, status 11, that cycle counted; undefined -> bp_addr ignored, no comparator synthesised, status 11 means abort only.

Structure
REQ-031 State encoding and status codes (STAT_NONE, STAT_HALT, STAT_TIMEOUT, STAT_ABORT) SHALL live in shared package risc_run_pkg.
REQ-032 Saturating counter SHALL be sub-module risc_sat_counter (parameter W, inputs clr, inc).

Verification
REQ-033 start, cycle_limit=10, halt_in=0 -> core_en high 10 cycles, done pulse, status=10, cycle_cnt=10.
REQ-034 start, cycle_limit=0, halt_in=1 on 7th enabled cycle -> status=01, cycle_cnt=7, core_en low after.
REQ-035 three step pulses from IDLE, 4 cycles apart -> three single core_en pulses, cycle_cnt=3, no done, state IDLE.
REQ-036 abort and halt_in both high on 5th enabled cycle, cycle_limit=5 -> status=11, cycle_cnt=5, one done pulse.
REQ-037 rst_n low mid-RUN at cycle_cnt=4 -> immediate core_en=0, cycle_cnt=0, status=00; new start runs normally.
REQ-038 CNT_W=4, cycle_limit=0, run 20 cycles then abort -> cycle_cnt saturates at 15; with macro defined, bp_addr=0x0003 and pc=0x0003 -> status=11.
